// File: rtl/alu_cnt_dec_unit_pkg.sv
// Shared opcodes and widths for the ALU / counter / decoder lab datapath.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu4_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_LT  = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  typedef logic [ALU_W-1:0] alu_word_t;

endpackage

// File: rtl/alu_cnt_dec_unit_if.sv
// Signal bundle between the board top level (switches/LEDs) and the datapath.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a plain level.
// Ports: master = board side (drives operands/enables, reads results),
//        slave  = datapath side.
interface alu_cnt_dec_unit_if;
  import alu4_pkg::*;

  logic [2:0] alu_fnselec;
  alu_word_t  alu_a;
  alu_word_t  alu_b;
  alu_word_t  alu_res;
  logic       alu_zero;
  logic       alu_overflow;
  logic       alu_carry;
  logic       cnt_en;
  logic [2:0] cnt_q;
  logic [2:0] dec_x;
  logic       dec_en;
  logic [7:0] dec_y;

  modport master (
    output alu_fnselec, alu_a, alu_b, cnt_en, dec_x, dec_en,
    input  alu_res, alu_zero, alu_overflow, alu_carry, cnt_q, dec_y
  );

  modport slave (
    input  alu_fnselec, alu_a, alu_b, cnt_en, dec_x, dec_en,
    output alu_res, alu_zero, alu_overflow, alu_carry, cnt_q, dec_y
  );

endinterface

// File: rtl/alu_cnt_dec_unit_core.sv
// alu4_core: 4-bit combinational ALU with zero/overflow/carry flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: fnselec (opcode), a/b (two's complement operands) in;
//        res, zero, overflow, carry out.
module alu4_core
  import alu4_pkg::*;
(
  input  logic [2:0] fnselec,
  input  alu_word_t  a,
  input  alu_word_t  b,
  output alu_word_t  res,
  output logic       zero,
  output logic       overflow,
  output logic       carry
);

  // One extra bit so the carry out of bit 3 falls out of the add.
  logic [ALU_W:0] sum;

  always_comb begin
    sum      = '0;
    res      = '0;
    overflow = 1'b0;
    carry    = 1'b0;
    case (fnselec)
      ALU_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        res      = sum[ALU_W-1:0];
        carry    = sum[ALU_W];
        overflow = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_SUB: begin
        // a + ~b + 1: carry set means no borrow occurred.
        sum      = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, 1'b1};
        res      = sum[ALU_W-1:0];
        carry    = sum[ALU_W];
        overflow = (a[ALU_W-1] != b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_NOT: res = ~a;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_LT:  res = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_EQ:  res = {{(ALU_W-1){1'b0}}, (a == b)};
      default: res = '0;
    endcase
  end

  assign zero = ~|res;

endmodule

// File: rtl/alu_cnt_dec_unit.sv
// Lab datapath: 4-bit ALU, 3-bit wrapping down counter, 3-to-8 decoder.
// Latency: ALU 0 cycles (1 cycle when ALU_OUT_REG_EN is defined); counter 1 edge; decoder 0.
// Backpressure: none; outputs follow inputs every cycle.
// Ports: clk, resetn (async active-low), bus (alu_cnt_dec_unit_if.slave).
// Build option: define ALU_OUT_REG_EN to register alu_res and the three flags.
module alu_cnt_dec_unit
  import alu4_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  alu_cnt_dec_unit_if.slave     bus
);

  alu_word_t core_res;
  logic      core_zero;
  logic      core_overflow;
  logic      core_carry;

  alu4_core u_alu (
    .fnselec  (bus.alu_fnselec),
    .a        (bus.alu_a),
    .b        (bus.alu_b),
    .res      (core_res),
    .zero     (core_zero),
    .overflow (core_overflow),
    .carry    (core_carry)
  );

`ifdef ALU_OUT_REG_EN
  // Reset value keeps zero consistent with a cleared result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.alu_res      <= '0;
      bus.alu_zero     <= 1'b1;
      bus.alu_overflow <= 1'b0;
      bus.alu_carry    <= 1'b0;
    end else begin
      bus.alu_res      <= core_res;
      bus.alu_zero     <= core_zero;
      bus.alu_overflow <= core_overflow;
      bus.alu_carry    <= core_carry;
    end
  end
`else
  assign bus.alu_res      = core_res;
  assign bus.alu_zero     = core_zero;
  assign bus.alu_overflow = core_overflow;
  assign bus.alu_carry    = core_carry;
`endif

  // Down counter; 0 wraps to 7 through natural 3-bit underflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.cnt_q <= 3'd0;
    end else if (bus.cnt_en) begin
      bus.cnt_q <= bus.cnt_q - 3'd1;
    end
  end

  always_comb begin
    bus.dec_y = 8'h00;
    if (bus.dec_en) begin
      bus.dec_y = 8'b1 << bus.dec_x;
    end
  end

endmodule

// File: tb/tb_alu_cnt_dec_unit.sv
// Self-checking bench for alu_cnt_dec_unit: directed literal vectors plus
// randomized traffic against an arithmetic reference model.
module tb_alu_cnt_dec_unit;

  logic clk;
  logic resetn;
  int   total;
  int   bad;
  bit   chk_on;

  // Model state
  int         cnt_m;
  logic [6:0] alu_reg;  // {res, zero, ovf, carry} for the registered build

  alu_cnt_dec_unit_if bus ();

  alu_cnt_dec_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] ALU_RST = 7'b0000_1_0_0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from integer arithmetic: returns {res, zero, ovf, carry}.
  function automatic logic [6:0] alu_model(input logic [2:0] fn, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, r, t;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (fn)
      3'd0: begin r = (ua + ub) & 15; c = (ua + ub) > 15; t = sa + sb; v = (t > 7) || (t < -8); end
      3'd1: begin r = (ua - ub) & 15; c = (ua >= ub);     t = sa - sb; v = (t > 7) || (t < -8); end
      3'd2: r = 15 - ua;
      3'd3: r = int'(a & b);
      3'd4: r = int'(a | b);
      3'd5: r = int'(a ^ b);
      3'd6: r = (sa < sb) ? 1 : 0;
      default: r = (ua == ub) ? 1 : 0;
    endcase
    return {r[3:0], (r == 0), v, c};
  endfunction

  function automatic logic [6:0] alu_now();
    return {bus.alu_res, bus.alu_zero, bus.alu_overflow, bus.alu_carry};
  endfunction

  // Advance one clock edge, updating the model with the values the DUT saw.
  task automatic step();
    @(posedge clk);
    if (resetn) begin
      if (bus.cnt_en) cnt_m = (cnt_m + 7) % 8;
      alu_reg = alu_model(bus.alu_fnselec, bus.alu_a, bus.alu_b);
    end
    #1;
  endtask

  task automatic assert_reset();
    resetn  = 1'b0;
    cnt_m   = 0;
    alu_reg = ALU_RST;
  endtask

  // Apply an ALU vector and check it against a hand-computed tuple.
  task automatic alu_vec(input string name, input logic [2:0] fn, input logic [3:0] a,
                         input logic [3:0] b, input logic [6:0] exp);
    bus.alu_fnselec = fn;
    bus.alu_a       = a;
    bus.alu_b       = b;
`ifdef ALU_OUT_REG_EN
    step();
`endif
    @(negedge clk);
    #1;
    chk(name, alu_now(), exp);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [6:0] exp_alu;
      int         exp_dec;
`ifdef ALU_OUT_REG_EN
      exp_alu = resetn ? alu_reg : ALU_RST;
`else
      exp_alu = alu_model(bus.alu_fnselec, bus.alu_a, bus.alu_b);
`endif
      exp_dec = bus.dec_en ? (2 ** int'(bus.dec_x)) : 0;
      chk("cyc_alu", alu_now(), exp_alu);
      chk("cyc_cnt", bus.cnt_q, resetn ? cnt_m : 0);
      chk("cyc_dec", bus.dec_y, exp_dec);
    end
  end

  initial begin
    logic [2:0] cnt_seq [9];
    logic [7:0] dec_tab [8];
    cnt_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    dec_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    total = 0;
    bad   = 0;
    bus.alu_fnselec = 3'd0;
    bus.alu_a  = 4'd0;
    bus.alu_b  = 4'd0;
    bus.cnt_en = 1'b0;
    bus.dec_x  = 3'd0;
    bus.dec_en = 1'b0;
    assert_reset();
    chk_on = 1'b1;

    // Reset state
    #2;
    chk("rst_cnt", bus.cnt_q, 3'd0);
    chk("rst_dec", bus.dec_y, 8'h00);
`ifdef ALU_OUT_REG_EN
    chk("rst_alu", alu_now(), ALU_RST);
`endif
    step();
    step();
    resetn = 1'b1;

    // Counter: 9 enabled edges from reset
    bus.cnt_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("cnt_seq%0d", i), bus.cnt_q, cnt_seq[i]);
    end
    bus.cnt_en = 1'b0;
    step();
    chk("cnt_hold1", bus.cnt_q, 3'd7);
    step();
    chk("cnt_hold2", bus.cnt_q, 3'd7);

    // Async reset mid-count, visible before any edge
    bus.cnt_en = 1'b1;
    step();
    step();
    chk("cnt_mid", bus.cnt_q, 3'd5);
    assert_reset();
    #1;
    chk("cnt_async_rst", bus.cnt_q, 3'd0);
`ifdef ALU_OUT_REG_EN
    chk("alu_async_rst", alu_now(), ALU_RST);
`endif
    step();
    resetn = 1'b1;
    step();
    chk("cnt_after_rst", bus.cnt_q, 3'd7);
    bus.cnt_en = 1'b0;

    // Decoder
    bus.dec_en = 1'b1;
    for (int x = 0; x < 8; x++) begin
      bus.dec_x = 3'(x);
      #1;
      chk($sformatf("dec_x%0d", x), bus.dec_y, dec_tab[x]);
      step();
    end
    bus.dec_en = 1'b0;
    bus.dec_x  = 3'd5;
    #1;
    chk("dec_off", bus.dec_y, 8'h00);

    // ALU literal vectors: {res, zero, ovf, carry}
    alu_vec("add_ovf",   3'b000, 4'b0111, 4'b0001, 7'b1000_0_1_0);
    alu_vec("add_carry", 3'b000, 4'b1111, 4'b0001, 7'b0000_1_0_1);
    alu_vec("sub_zero",  3'b001, 4'b0011, 4'b0011, 7'b0000_1_0_1);
    alu_vec("sub_ovf",   3'b001, 4'b1000, 4'b0001, 7'b0111_0_1_1);
    alu_vec("sub_borrow",3'b001, 4'b0001, 4'b0010, 7'b1111_0_0_0);
    alu_vec("lt_neg",    3'b110, 4'b1110, 4'b0001, 7'b0001_0_0_0);
    alu_vec("eq",        3'b111, 4'b1010, 4'b1010, 7'b0001_0_0_0);
    alu_vec("and",       3'b011, 4'b1100, 4'b1010, 7'b1000_0_0_0);
    alu_vec("not",       3'b010, 4'b0000, 4'b0101, 7'b1111_0_0_0);
    alu_vec("or",        3'b100, 4'b0101, 4'b0010, 7'b0111_0_0_0);
    alu_vec("xor_zero",  3'b101, 4'b1010, 4'b1010, 7'b0000_1_0_0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step();
      if ($urandom_range(0, 49) == 0) begin
        assert_reset();
      end else begin
        resetn = 1'b1;
      end
      bus.alu_fnselec = 3'($urandom_range(0, 7));
      bus.alu_a       = 4'($urandom_range(0, 15));
      bus.alu_b       = 4'($urandom_range(0, 15));
      bus.cnt_en      = 1'($urandom_range(0, 3) != 0);
      bus.dec_x       = 3'($urandom_range(0, 7));
      bus.dec_en      = 1'($urandom_range(0, 1));
    end
    step();
    resetn = 1'b1;
    step();
    step();
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
